// File: rtl/t5_lsu.sv
// t5_lsu: single-outstanding load/store unit between a core request port and a
// Wishbone-style data bus, with lane steering, load extension and a bus timeout.
module t5_lsu #(
    parameter int XLEN = 32,
    parameter int TMO  = 255
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            sys_ena,
    input  logic            lsu_req,
    input  logic            lsu_wre,
    input  logic [1:0]      lsu_siz,
    input  logic            lsu_uns,
    input  logic [XLEN-1:0] lsu_adr,
    input  logic [XLEN-1:0] lsu_dat,
    output logic            lsu_busy,
    output logic            lsu_done,
    output logic            lsu_err,
    output logic [XLEN-1:0] lsu_rdat,
    output logic [XLEN-3:0] dwb_adr,
    output logic [XLEN-1:0] dwb_dto,
    output logic [3:0]      dwb_sel,
    output logic            dwb_stb,
    output logic            dwb_wre,
    input  logic            dwb_ack,
    input  logic [XLEN-1:0] dwb_dti
);

    // The counter only has to reach TMO-1: the edge that would make it TMO is the timeout edge.
    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TMO > 0) ? TMO - 1 : 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-3:0] adr_q, adr_d;
    logic [XLEN-1:0] dto_q, dto_d;
    logic [XLEN-1:0] rdat_q, rdat_d;
    logic [3:0]      sel_q, sel_d;
    logic            wre_q, wre_d;
    logic            uns_q, uns_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [1:0]      siz_q, siz_d;
    logic [1:0]      lo_q, lo_d;

    logic            aligned;
    logic [3:0]      sel_new;
    logic [XLEN-1:0] dto_new;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] ld_val;

    always_comb begin
        aligned = 1'b0;
        sel_new = 4'h0;
        dto_new = lsu_dat;
        case (lsu_siz)
            2'd0: begin
                aligned = 1'b1;
                sel_new = 4'b0001 << lsu_adr[1:0];
                dto_new = {4{lsu_dat[7:0]}};
            end
            2'd1: begin
                aligned = !lsu_adr[0];
                sel_new = lsu_adr[1] ? 4'hC : 4'h3;
                dto_new = {2{lsu_dat[15:0]}};
            end
            2'd2: begin
                aligned = (lsu_adr[1:0] == 2'b00);
                sel_new = 4'hF;
                dto_new = lsu_dat;
            end
            default: begin
                aligned = 1'b0;
            end
        endcase
    end

    // Right-justify the addressed lane, then extend according to the latched size.
    always_comb begin
        lane = dwb_dti >> {lo_q, 3'b000};
        case (siz_q)
            2'd0:    ld_val = {{(XLEN-8){!uns_q & lane[7]}}, lane[7:0]};
            2'd1:    ld_val = {{(XLEN-16){!uns_q & lane[15]}}, lane[15:0]};
            default: ld_val = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dto_d   = dto_q;
        rdat_d  = rdat_q;
        sel_d   = sel_q;
        wre_d   = wre_q;
        uns_d   = uns_q;
        siz_d   = siz_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lsu_req && sys_ena) begin
                    if (aligned) begin
                        state_d = S_BUS;
                        cnt_d   = '0;
                        adr_d   = lsu_adr[XLEN-1:2];
                        dto_d   = dto_new;
                        sel_d   = sel_new;
                        wre_d   = lsu_wre;
                        uns_d   = lsu_uns;
                        siz_d   = lsu_siz;
                        lo_d    = lsu_adr[1:0];
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            S_BUS: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (dwb_ack) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (!wre_q) begin
                        rdat_d = ld_val;
                    end
                end else if (TMO != 0 && cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dto_q   <= '0;
            rdat_q  <= '0;
            sel_q   <= '0;
            wre_q   <= 1'b0;
            uns_q   <= 1'b0;
            siz_q   <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dto_q   <= dto_d;
            rdat_q  <= rdat_d;
            sel_q   <= sel_d;
            wre_q   <= wre_d;
            uns_q   <= uns_d;
            siz_q   <= siz_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign lsu_busy = (state_q == S_BUS);
    assign dwb_stb  = (state_q == S_BUS);
    assign dwb_wre  = wre_q;
    assign dwb_adr  = adr_q;
    assign dwb_sel  = sel_q;
    assign dwb_dto  = dto_q;
    assign lsu_done = done_q;
    assign lsu_err  = err_q;
    assign lsu_rdat = rdat_q;

endmodule
